// File: rtl/uart_line_arbiter_pkg.sv
// Shared types for the UART line arbiter: FSM encoding, grant index width, pointer helper.
package uart_line_arbiter_pkg;

  localparam int MAX_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO
  } arb_state_t;

  // Round-robin successor of id among n requesters.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id, input int n);
    if (int'(id) >= n - 1) return '0;
    return id + ID_W'(1);
  endfunction

endpackage

// File: rtl/uart_line_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping to the bottom.
module rr_pick
  import uart_line_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            hit,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = ptr;
    // Wrapped region first; the upper region then overrides, lowest index wins in each.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i < int'(ptr))) begin
        hit = 1'b1;
        idx = ID_W'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        hit = 1'b1;
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_line_arbiter.sv
// Grants whole lines round-robin onto one uart_tx; byte accepted 1 cycle after grant, start 1 cycle later.
// Producers are stalled until the transmitter's busy has risen and fallen; a silent grantee is revoked on timeout.
module uart_line_arbiter
  import uart_line_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int IDLE_TIMEOUT = 5_000_000,
  parameter int TMO_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     s_valid,
  input  logic [8*N_REQ-1:0]   s_data,
  input  logic [N_REQ-1:0]     s_last,
  output logic [N_REQ-1:0]     s_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_pulse
);

  localparam int              DW        = 8 * MAX_REQ;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(IDLE_TIMEOUT - 1);

  arb_state_t       state, state_d;
  logic [ID_W-1:0]  rr_ptr;
  logic [TMO_W-1:0] tmo_cnt;
  logic             last_q;

  logic             pick_hit;
  logic [ID_W-1:0]  pick_idx;
  logic             accept;
  logic             tmo_hit;
  logic             line_done;

  // Widen the request buses so the 3-bit grant index addresses them exactly.
  logic [MAX_REQ-1:0] valid_pad;
  logic [MAX_REQ-1:0] last_pad;
  logic [DW-1:0]      data_pad;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;

  assign valid_pad = MAX_REQ'(s_valid);
  assign last_pad  = MAX_REQ'(s_last);
  assign data_pad  = DW'(s_data);
  assign sel_valid = valid_pad[grant_id];
  assign sel_last  = last_pad[grant_id];
  assign sel_data  = data_pad[{grant_id, 3'b000} +: 8];

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req (s_valid),
    .ptr (rr_ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  always_comb begin
    state_d       = state;
    accept        = 1'b0;
    tmo_hit       = 1'b0;
    line_done     = 1'b0;
    tx_start      = 1'b0;
    timeout_pulse = 1'b0;
    s_ready       = '0;
    case (state)
      ST_IDLE: begin
        if (pick_hit) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (sel_valid && !tx_busy) begin
          accept  = 1'b1;
          state_d = ST_START;
        end else if (!sel_valid && (tmo_cnt == TMO_LIMIT)) begin
          tmo_hit       = 1'b1;
          timeout_pulse = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_START: begin
        tx_start = 1'b1;
        state_d  = ST_WAIT_HI;
      end
      // busy may still read low on the cycle after start; wait for it to rise first.
      ST_WAIT_HI: begin
        if (tx_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          line_done = last_q;
          state_d   = last_q ? ST_IDLE : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    for (int i = 0; i < N_REQ; i++) begin
      s_ready[i] = accept && (grant_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      last_q      <= 1'b0;
      tx_data     <= 8'h00;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      state <= state_d;
      if ((state == ST_IDLE) && pick_hit) begin
        grant_id    <= pick_idx;
        grant_valid <= 1'b1;
        tmo_cnt     <= '0;
      end
      if (accept) begin
        tx_data <= sel_data;
        last_q  <= sel_last;
        tmo_cnt <= '0;
      end else if ((state == ST_FETCH) && !sel_valid) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (tmo_hit || line_done) begin
        grant_valid <= 1'b0;
        rr_ptr      <= next_id(grant_id, N_REQ);
      end
    end
  end

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Directed bench for uart_line_arbiter with a behavioural uart_tx busy model and queue-driven producers.
module tb_uart_line_arbiter;

  localparam int N     = 4;
  localparam int TMO   = 16;
  localparam int FRAME = 6;
  localparam int BOUND = 4000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     s_valid = '0;
  logic [8*N-1:0]   s_data  = '0;
  logic [N-1:0]     s_last  = '0;
  logic [N-1:0]     s_ready;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             grant_valid;
  logic [2:0]       grant_id;
  logic             timeout_pulse;

  int n_chk = 0;
  int n_err = 0;

  logic [8:0]  pq [N][$];
  logic [10:0] log_q [$];
  int          start_cyc [$];
  int          rdy0_cyc [$];
  int          rdy_cnt [N];
  int          cyc = 0;
  int          busy_cnt = 0;
  int          fall_cyc = 0;
  int          tmo_n = 0;
  int          tmo_delta = -1;
  int          onehot_err = 0;
  int          overlap_err = 0;
  logic        busy_prev = 1'b0;
  logic [N-1:0] rdy_s;
  logic        st_s;

  always #5 clk = ~clk;

  assign tx_busy = (busy_cnt != 0) && !rst;

  uart_line_arbiter #(
    .N_REQ        (N),
    .IDLE_TIMEOUT (TMO),
    .TMO_W        (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] log_at(input int k);
    if (k < log_q.size()) return log_q[k];
    return 11'h7FF;
  endfunction

  // Sample mid-cycle, then update producers and the transmitter model just after the edge.
  initial begin
    forever begin
      @(negedge clk);
      rdy_s = s_ready;
      st_s  = tx_start;
      if ((s_ready & (s_ready - 4'd1)) != 4'd0) onehot_err++;
      if (tx_start && tx_busy) overlap_err++;
      if (tx_start) begin
        log_q.push_back({grant_id, tx_data});
        start_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) if (s_ready[i]) rdy_cnt[i]++;
      if (s_ready[0]) rdy0_cyc.push_back(cyc);
      if (busy_prev && !tx_busy) fall_cyc = cyc;
      busy_prev = tx_busy;
      if (timeout_pulse) begin
        tmo_n++;
        tmo_delta = cyc - fall_cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy_cnt > 0) busy_cnt--;
        if (st_s) busy_cnt = FRAME;
        for (int i = 0; i < N; i++) begin
          if (rdy_s[i] && (pq[i].size() > 0)) void'(pq[i].pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        s_valid[i]       = (pq[i].size() > 0);
        s_data[8*i +: 8] = (pq[i].size() > 0) ? pq[i][0][7:0] : 8'h00;
        s_last[i]        = (pq[i].size() > 0) ? pq[i][0][8] : 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_logs();
    log_q.delete();
    start_cyc.delete();
    rdy0_cyc.delete();
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    tmo_n = 0;
    tmo_delta = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) pq[i].delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_log(input int n);
    int t;
    t = 0;
    @(negedge clk);
    while ((log_q.size() < n) && (t < BOUND)) begin
      @(negedge clk);
      t++;
    end
    if (t >= BOUND) check("wait_log_bound", t, 0);
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    @(negedge clk);
    while (!((log_q.size() >= n) && !grant_valid && !tx_busy) && (t < BOUND)) begin
      @(negedge clk);
      t++;
    end
    if (t >= BOUND) check("wait_done_bound", t, 0);
  endtask

  initial begin
    logic [7:0] hi [4];
    hi[0] = 8'h48; hi[1] = 8'h49; hi[2] = 8'h0D; hi[3] = 8'h0A;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_timeout", 32'(timeout_pulse), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    clear_logs();

    // Single line "HI\r\n" with first-transaction latency.
    @(negedge clk);
    for (int k = 0; k < 4; k++) pq[0].push_back({1'(k == 3), hi[k]});
    @(negedge clk);
    check("lat_c0_valid", 32'(s_valid[0]), 1);
    check("lat_c0_grant", 32'(grant_valid), 0);
    @(negedge clk);
    check("lat_c1_grant", 32'(grant_valid), 1);
    check("lat_c1_ready", 32'(s_ready), 32'h1);
    @(negedge clk);
    check("lat_c2_start", 32'(tx_start), 1);
    check("lat_c2_data", 32'(tx_data), 32'h48);
    wait_done(4);
    for (int k = 0; k < 4; k++) check("line_hi_byte", 32'(log_at(k)), 32'({3'd0, hi[k]}));
    check("line_hi_ready_cnt", rdy_cnt[0], 4);
    check("line_hi_ready_gap", (rdy0_cyc.size() > 1) ? rdy0_cyc[1] - rdy0_cyc[0] : -1, FRAME + 3);
    check("line_hi_grant_end", 32'(grant_valid), 0);
    check("line_hi_bytes", log_q.size(), 4);

    // Round-robin fairness: four 3-byte lines pending together, twice.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) pq[i].push_back({1'(k == 2), 8'(8'h30 + 16*i + k)});
    wait_done(12);
    for (int j = 0; j < 12; j++)
      check("rr_set1", 32'(log_at(j)), 32'({3'(j/3), 8'(8'h30 + 16*(j/3) + j%3)}));
    check("rr_grant_id_hold", 32'(grant_id), 3);
    check("rr_grant_valid_end", 32'(grant_valid), 0);
    check("rr_byte_spacing", (start_cyc.size() > 1) ? start_cyc[1] - start_cyc[0] : -1, FRAME + 3);
    check("rr_line_spacing", (start_cyc.size() > 3) ? start_cyc[3] - start_cyc[2] : -1, FRAME + 4);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) pq[i].push_back({1'(k == 2), 8'(8'h60 + 16*i + k)});
    wait_done(24);
    for (int i = 0; i < N; i++)
      check("rr_set2_line", 32'(log_at(12 + 3*i)), 32'({3'(i), 8'(8'h60 + 16*i)}));

    // No interleave: requester 1 arrives mid-line.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 5; k++) pq[0].push_back({1'(k == 4), 8'(8'h41 + k)});
    wait_log(2);
    pq[1].push_back({1'b0, 8'h61});
    pq[1].push_back({1'b1, 8'h62});
    wait_log(5);
    check("nointlv_ready1_held", rdy_cnt[1], 0);
    wait_done(7);
    check("nointlv_last0", 32'(log_at(4)), 32'({3'd0, 8'h45}));
    check("nointlv_first1", 32'(log_at(5)), 32'({3'd1, 8'h61}));
    check("nointlv_second1", 32'(log_at(6)), 32'({3'd1, 8'h62}));

    // Timeout: requester 2 stalls mid-line, requester 3 waits.
    do_reset();
    @(negedge clk);
    pq[2].push_back({1'b0, 8'hB2});
    pq[3].push_back({1'b0, 8'hC1});
    pq[3].push_back({1'b1, 8'hC2});
    wait_done(3);
    check("tmo_count", tmo_n, 1);
    check("tmo_delay", tmo_delta, TMO);
    check("tmo_byte2", 32'(log_at(0)), 32'({3'd2, 8'hB2}));
    check("tmo_byte3a", 32'(log_at(1)), 32'({3'd3, 8'hC1}));
    check("tmo_byte3b", 32'(log_at(2)), 32'({3'd3, 8'hC2}));
    check("tmo_ready2_cnt", rdy_cnt[2], 1);

    // Reset during WAIT_LO of byte 2 of 4.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) pq[1].push_back({1'(k == 3), 8'(8'hD0 + k)});
    wait_log(2);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_grant_valid", 32'(grant_valid), 0);
    check("midrst_tx_data", 32'(tx_data), 0);
    check("midrst_s_ready", 32'(s_ready), 0);
    check("midrst_grant_id", 32'(grant_id), 0);
    check("midrst_ready1_cnt", rdy_cnt[1], 2);
    do_reset();
    @(negedge clk);
    pq[0].push_back({1'b1, 8'hE0});
    pq[2].push_back({1'b1, 8'hE2});
    wait_done(2);
    check("postrst_first", 32'(log_at(0)), 32'({3'd0, 8'hE0}));
    check("postrst_second", 32'(log_at(1)), 32'({3'd2, 8'hE2}));
    check("postrst_ready1", rdy_cnt[1], 0);

    check("ready_onehot", onehot_err, 0);
    check("start_while_busy", overlap_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
